// File: rtl/vending_pkg.sv
// Shared types for the vending order controller: the state encoding, the
// display status codes, and helpers for decoding selects and states.
package vending_pkg;

  localparam int unsigned MAX_PROD  = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StCheck    = 3'b001,
    StNoStock  = 3'b101,
    StWaitPay  = 3'b111,
    StDispense = 3'b011,
    StThanks   = 3'b110,
    StCancel   = 3'b100
  } state_e;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_CHECK    = 3'b001;
  localparam logic [2:0] ST_NOSTOCK  = 3'b101;
  localparam logic [2:0] ST_WAIT_PAY = 3'b111;
  localparam logic [2:0] ST_DISPENSE = 3'b011;
  localparam logic [2:0] ST_THANKS   = 3'b110;
  localparam logic [2:0] ST_CANCEL   = 3'b100;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } onehot_t;

  // valid only when exactly one bit is set; idx is then that bit's position
  function automatic onehot_t onehot_decode(input logic [MAX_PROD-1:0] vec);
    onehot_t     r;
    int unsigned ones;
    r.valid = 1'b0;
    r.idx   = '0;
    ones    = 0;
    for (int unsigned i = 0; i < MAX_PROD; i++) begin
      if (vec[i]) begin
        ones  = ones + 1;
        r.idx = MAX_IDX_W'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

  function automatic logic [2:0] status_of(input state_e s);
    logic [2:0] code;
    case (s)
      StIdle:     code = ST_IDLE;
      StCheck:    code = ST_CHECK;
      StNoStock:  code = ST_NOSTOCK;
      StWaitPay:  code = ST_WAIT_PAY;
      StDispense: code = ST_DISPENSE;
      StThanks:   code = ST_THANKS;
      StCancel:   code = ST_CANCEL;
      default:    code = ST_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/inventory_counter.sv
// Saturating per-product stock counter; simultaneous inc and dec cancel out.
module inventory_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned INIT  = 5
) (
  input  logic             clk1,
  input  logic             reset1,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned      MAX_VAL  = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = '1;
  localparam logic [CNT_W-1:0] INIT_VAL = (INIT > MAX_VAL) ? MAX_CNT : CNT_W'(INIT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      count_q <= INIT_VAL;
    end else if (inc && !dec && (count_q != MAX_CNT)) begin
      count_q <= count_q + CNT_W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vending_ctrl_multi.sv
// Vending order controller: select, stock check, payment wait with timeout,
// dispense and per-product inventory tracking.
module vending_ctrl_multi
  import vending_pkg::*;
#(
  parameter int unsigned N_PROD   = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned INV_INIT = 5,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                    clk1,
  input  logic                    reset1,
  input  logic [N_PROD-1:0]       sel,
  input  logic                    pay,
  input  logic                    cancel,
  input  logic [N_PROD-1:0]       restock,
  output logic [2:0]              status,
  output logic [N_PROD-1:0]       dispense,
  output logic                    busy,
  output logic [N_PROD-1:0]       inv_empty,
  output logic [N_PROD*CNT_W-1:0] inv_count
);

  localparam int unsigned IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_PROD-1:0]   disp_d;
  logic [MAX_PROD-1:0] sel_ext;
  onehot_t             oh;

  assign sel_ext = MAX_PROD'(sel);
  assign oh      = onehot_decode(sel_ext);

  always_comb begin
    state_d = StIdle;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (oh.valid) begin
          idx_d   = IDX_W'(oh.idx);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!inv_empty[idx_q]) begin
          state_d = StWaitPay;
          timer_d = '0;
        end else begin
          state_d = StNoStock;
        end
      end
      StNoStock: state_d = StCancel;
      StWaitPay: begin
        timer_d = timer_q + TW'(1);
        // pay alone beats the timeout when both land on the same edge
        if (pay && !cancel) begin
          state_d = StDispense;
        end else if (cancel && !pay) begin
          state_d = StCancel;
        end else if (timer_q == TIMER_LAST) begin
          state_d = StCancel;
        end else begin
          state_d = StWaitPay;
        end
      end
      StDispense: state_d = StThanks;
      StThanks:   state_d = StIdle;
      StCancel:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    disp_d = '0;
    if (state_d == StDispense) begin
      disp_d[idx_d] = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      timer_q  <= '0;
      status   <= ST_IDLE;
      busy     <= 1'b0;
      dispense <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      status   <= status_of(state_d);
      busy     <= (state_d != StIdle);
      dispense <= disp_d;
    end
  end

  // The dispense pulse doubles as the decrement strobe for the exit edge.
  for (genvar i = 0; i < N_PROD; i++) begin : g_inv
    inventory_counter #(
      .CNT_W (CNT_W),
      .INIT  (INV_INIT)
    ) u_cnt (
      .clk1   (clk1),
      .reset1 (reset1),
      .inc    (restock[i]),
      .dec    (dispense[i]),
      .count  (inv_count[i*CNT_W +: CNT_W]),
      .empty  (inv_empty[i])
    );
  end

endmodule
